// File: rtl/data_types_pkg.sv
// Shared types and constants for the I2C slave responder: FSM states,
// default bus widths and the R/W bit encoding of the address byte.
package data_types_pkg;

  localparam int I2C_ADDR_WIDTH_DEF = 7;
  localparam int I2C_DATA_WIDTH_DEF = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_bus_cond_det.sv
// Synchronises raw SCL/SDA into the clock domain and decodes SCL edges
// plus START/STOP conditions from the synchronised values.
module i2c_bus_cond_det (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // p0/p1: two-flop synchroniser, p2: history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_raw;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_raw;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign sda      = sda_p1;
  assign scl_rise = scl_p1 & ~scl_p2;
  assign scl_fall = ~scl_p1 & scl_p2;
  assign start    = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop     = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_slave_resp.sv
// I2C slave responder: ACKs its address, streams written bytes out on
// wr_data_o and serves read bytes requested through rd_req_o/rd_data_i.
module i2c_slave_resp
  import data_types_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = I2C_ADDR_WIDTH_DEF,
  parameter int                        I2C_DATA_WIDTH = I2C_DATA_WIDTH_DEF,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h69
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      busy_o
);

  localparam int DW = I2C_DATA_WIDTH;
  localparam int AW = I2C_ADDR_WIDTH;

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_cond_det u_det (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .scl_raw  (scl_i),
    .sda_raw  (sda_i),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  state_t          state, state_nx;
  logic [2:0]      cnt, cnt_nx;
  logic [DW-2:0]   shreg, shreg_nx;
  logic [DW-1:0]   tx, tx_nx;
  logic [DW-1:0]   byte_in;
  logic [DW-1:0]   wr_data_nx;
  logic            sda_nx, wr_valid_nx, rd_req_nx, start_nx, stop_nx, busy_nx;
  logic            rd_req_d;

  assign scl_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      sda_o      <= 1'b1;
      wr_data_o  <= '0;
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      rd_req_d   <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sda_o      <= sda_nx;
      wr_data_o  <= wr_data_nx;
      wr_valid_o <= wr_valid_nx;
      rd_req_o   <= rd_req_nx;
      rd_req_d   <= rd_req_o;
      start_o    <= start_nx;
      stop_o     <= stop_nx;
      busy_o     <= busy_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    shreg <= shreg_nx;
    tx    <= tx_nx;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    shreg_nx    = shreg;
    tx_nx       = tx;
    sda_nx      = sda_o;
    wr_data_nx  = wr_data_o;
    wr_valid_nx = 1'b0;
    rd_req_nx   = 1'b0;
    start_nx    = 1'b0;
    stop_nx     = 1'b0;
    busy_nx     = busy_o;
    byte_in     = {shreg, sda};

    // Read byte arrives on rd_data_i the cycle after the request pulse
    if (rd_req_d) tx_nx = rd_data_i;

    if (start) begin
      state_nx = ADDR;
      cnt_nx   = 3'd0;
      sda_nx   = 1'b1;
      start_nx = 1'b1;
      busy_nx  = 1'b0;
    end else if (stop) begin
      state_nx = IDLE;
      sda_nx   = 1'b1;
      stop_nx  = 1'b1;
      busy_nx  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_nx = byte_in[DW-2:0];
            cnt_nx   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              sda_nx = 1'b1;
              if (byte_in[DW-1 -: AW] == SLAVE_ADDR) begin
                state_nx  = ADDR_ACK;
                busy_nx   = 1'b1;
                rd_req_nx = (byte_in[0] == RW_READ);
              end else begin
                state_nx = WAIT_STOP;
              end
            end
          end
        end
        // ACK states pull SDA low on the fall and move on at the ACK rise
        ADDR_ACK: begin
          if (scl_fall)      sda_nx = 1'b0;
          else if (scl_rise) state_nx = (shreg[0] == RW_READ) ? RD_DATA : WR_DATA;
        end
        WR_DATA: begin
          if (scl_fall) begin
            sda_nx = 1'b1;
          end else if (scl_rise) begin
            shreg_nx = byte_in[DW-2:0];
            cnt_nx   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              wr_data_nx  = byte_in;
              wr_valid_nx = 1'b1;
              state_nx    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall)      sda_nx = 1'b0;
          else if (scl_rise) state_nx = WR_DATA;
        end
        RD_DATA: begin
          if (scl_fall) begin
            sda_nx = tx[DW-1];
            tx_nx  = {tx[DW-2:0], 1'b1};
          end else if (scl_rise) begin
            cnt_nx = cnt + 3'd1;
            if (cnt == 3'd7) state_nx = RD_ACK;
          end
        end
        RD_ACK: begin
          if (scl_fall) begin
            sda_nx = 1'b1;
          end else if (scl_rise) begin
            if (!sda) begin
              rd_req_nx = 1'b1;
              state_nx  = RD_DATA;
            end else begin
              state_nx = WAIT_STOP;
              busy_nx  = 1'b0;
            end
          end
        end
        WAIT_STOP: sda_nx = 1'b1;
        default:   sda_nx = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_resp.sv
// Directed bench for i2c_slave_resp: a bit-banged I2C master on a
// wired-AND SDA line, with pulse monitors and immediate-assertion checks.
module tb_i2c_slave_resp;
  import data_types_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] rd_data = 8'h00;
  logic       scl_o, sda_o, wr_valid, rd_req, start_o, stop_o, busy;
  logic [7:0] wr_data;
  wire        sda_bus = sda_m & sda_o;

  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0, rd_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic [7:0] wr_log [0:63];

  always #5 clk = ~clk;

  i2c_slave_resp dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .wr_data_o  (wr_data),
    .wr_valid_o (wr_valid),
    .rd_req_o   (rd_req),
    .rd_data_i  (rd_data),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .busy_o     (busy)
  );

  always @(posedge clk) begin
    if (wr_valid) begin
      wr_log[wr_cnt % 64] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (rd_req)  rd_cnt    <= rd_cnt + 1;
    if (start_o) start_cnt <= start_cnt + 1;
    if (stop_o)  stop_cnt  <= stop_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl   = 1'b1; wait_clk(2*Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl   = 1'b1; wait_clk(Q);
    b     = sda_bus; wait_clk(Q);
    scl   = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack_bit);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] rx;
    int         base_wr, base_rd, base_st, base_sp, n_ack;

    // Reset state
    wait_clk(5);
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_scl_o", scl_o, 1'b1);
    check("rst_wr_data", wr_data, 8'h00);
    check("rst_pulses", {wr_valid, rd_req, start_o, stop_o}, 4'b0000);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(5);

    // Write 0x00..0x1F to 0x69
    base_wr = wr_cnt; base_sp = stop_cnt; base_st = start_cnt;
    n_ack = 0;
    bus_start();
    write_byte(8'hD2, ack);
    if (ack == 1'b0) n_ack++;
    check("wr_addr_ack", ack, 1'b0);
    check("wr_busy", busy, 1'b1);
    for (int i = 0; i < 32; i++) begin
      write_byte(i[7:0], ack);
      if (ack == 1'b0) n_ack++;
    end
    bus_stop();
    wait_clk(4);
    check("wr_ack_count", n_ack, 33);
    check("wr_valid_count", wr_cnt - base_wr, 32);
    for (int i = 0; i < 32; i++) check("wr_byte", wr_log[(base_wr + i) % 64], i[7:0]);
    check("wr_last_data", wr_data, 8'h1F);
    check("wr_stop_count", stop_cnt - base_sp, 1);
    check("wr_start_count", start_cnt - base_st, 1);
    check("wr_busy_after_stop", busy, 1'b0);

    // Read 4 bytes of 0xA5, NACK on the last
    base_rd = rd_cnt;
    rd_data = 8'hA5;
    bus_start();
    write_byte(8'hD3, ack);
    check("rd_addr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) begin
      read_byte(rx, (i == 3) ? 1'b1 : 1'b0);
      check("rd_byte", rx, 8'hA5);
    end
    wait_clk(4);
    check("rd_req_count", rd_cnt - base_rd, 4);
    check("rd_state_wait_stop", dut.state, WAIT_STOP);
    check("rd_busy_after_nack", busy, 1'b0);
    check("rd_sda_released", sda_o, 1'b1);
    bus_stop();
    wait_clk(4);

    // Address 0x42 is not ours
    base_wr = wr_cnt;
    bus_start();
    write_byte(8'h84, ack);
    check("na_no_ack", ack, 1'b1);
    check("na_busy", busy, 1'b0);
    write_byte(8'h55, ack);
    check("na_data_no_ack", ack, 1'b1);
    bus_stop();
    wait_clk(4);
    check("na_no_wr_valid", wr_cnt - base_wr, 0);

    // Write 0x12, repeated START, read
    base_st = start_cnt; base_sp = stop_cnt; base_rd = rd_cnt;
    rd_data = 8'h3C;
    bus_start();
    write_byte(8'hD2, ack);
    check("rs_wr_addr_ack", ack, 1'b0);
    write_byte(8'h12, ack);
    check("rs_wr_data_ack", ack, 1'b0);
    check("rs_wr_data", wr_data, 8'h12);
    bus_start();
    write_byte(8'hD3, ack);
    check("rs_rd_addr_ack", ack, 1'b0);
    check("rs_start_count", start_cnt - base_st, 2);
    check("rs_no_stop", stop_cnt - base_sp, 0);
    check("rs_rd_req", rd_cnt - base_rd, 1);
    read_byte(rx, 1'b1);
    check("rs_rd_byte", rx, 8'h3C);
    bus_stop();
    wait_clk(4);
    check("rs_stop_count", stop_cnt - base_sp, 1);

    // Reset during bit 4 of a read byte
    rd_data = 8'hA5;
    bus_start();
    write_byte(8'hD3, ack);
    check("mr_addr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) read_bit(b);
    check("mr_driving_bit", sda_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mr_async_release", sda_o, 1'b1);
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(5);
    check("mr_busy_in_reset", busy, 1'b0);
    rst_n = 1'b1;
    wait_clk(10);
    check("mr_idle_after_reset", dut.state, IDLE);
    base_wr = wr_cnt;
    bus_start();
    write_byte(8'hD2, ack);
    check("mr_next_addr_ack", ack, 1'b0);
    write_byte(8'h5A, ack);
    check("mr_next_data_ack", ack, 1'b0);
    bus_stop();
    wait_clk(4);
    check("mr_next_wr_data", wr_data, 8'h5A);
    check("mr_next_wr_count", wr_cnt - base_wr, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_resp.md
I2C_SLAVE_RESP -- requirements
Module: i2c_slave_resp

Interface
REQ-001 SHALL have parameter I2C_ADDR_WIDTH, default 7: width of the slave address.
REQ-002 SHALL have parameter I2C_DATA_WIDTH, default 8: width of a data byte.
REQ-003 SHALL have parameter SLAVE_ADDR, default 7'h69: the address this block responds to.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; port names are clk_i and rst_n_i.
REQ-005 clk_i  in  1  system clock; frequency at least 16x SCL.
REQ-006 rst_n_i  in  1  asynchronous active-low reset.
REQ-007 scl_i  in  1  I2C clock, raw bus value.
REQ-008 sda_i  in  1  I2C data, raw bus value.
REQ-009 scl_o  out  1  SCL open-drain output; permanently 1 (released, no clock stretching).
REQ-010 sda_o  out  1  SDA open-drain output; 0 drives the bus low, 1 releases it.
REQ-011 wr_data_o  out  I2C_DATA_WIDTH  last byte received in a write transfer.
REQ-012 wr_valid_o  out  1  one-cycle pulse when wr_data_o updates.
REQ-013 rd_req_o  out  1  one-cycle pulse requesting the next read byte.
REQ-014 rd_data_i  in  I2C_DATA_WIDTH  read byte; sampled exactly 1 cycle after rd_req_o.
REQ-015 start_o  out  1  one-cycle pulse on a START or repeated START.
REQ-016 stop_o  out  1  one-cycle pulse on a STOP.
REQ-017 busy_o  out  1  high from an address match until STOP, repeated START, or master NACK.

Function
REQ-018 SHALL pass scl_i and sda_i through 2-flop synchronizers, then one history flop for edge detection; all decoding uses the synchronized values.
REQ-019 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-020 SHALL sample SDA on the SCL rising edge and change sda_o only on the cycle after an SCL falling edge is detected.
REQ-021 FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-022 START in any state SHALL go to ADDR, clear the bit counter, release sda_o and pulse start_o.
REQ-023 STOP in any state SHALL go to IDLE, release sda_o and pulse stop_o; a simultaneous START/STOP cannot occur.
REQ-024 ADDR SHALL shift in MSB-first the 7 address bits plus the R/W bit; after the 8th rising edge it goes to ADDR_ACK on a match, otherwise to WAIT_STOP with sda_o released.
REQ-025 ADDR_ACK SHALL drive sda_o=0 for the ACK SCL high period, then go to WR_DATA if R/W=0 or RD_DATA if R/W=1; for a read, rd_req_o pulses at entry to ADDR_ACK.
REQ-026 WR_DATA SHALL shift 8 bits; on the 8th rising edge it loads wr_data_o, pulses wr_valid_o and enters WR_ACK, which always ACKs and then returns to WR_DATA.
REQ-027 RD_DATA SHALL drive the latched byte MSB-first, one bit per SCL low phase; after 8 bits it enters RD_ACK with sda_o released.
REQ-028 RD_ACK SHALL sample the master ACK on the rising edge: SDA=0 pulses rd_req_o and returns to RD_DATA; SDA=1 (NACK) goes to WAIT_STOP.
REQ-029 WAIT_STOP SHALL hold sda_o=1 and leave only on START or STOP.
REQ-030 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary; the counter is never reloaded mid-byte except by START.
REQ-031 sda_o SHALL be 1 whenever it is not driving an ACK or a read data bit.

Reset
REQ-032 While rst_n_i=0: state=IDLE, sda_o=1, scl_o=1, wr_data_o=0, all pulses=0, busy_o=0, synchronizers preset to 1.
REQ-033 A reset asserted mid-transfer SHALL release SDA immediately (asynchronously) and ignore the bus until the next START after rst_n_i deasserts.

Structure
REQ-034 The state enum, I2C_ADDR_WIDTH/I2C_DATA_WIDTH defaults and R/W bit encoding SHALL live in data_types_pkg.
REQ-035 The synchronizer plus START/STOP/edge detector SHALL be one sub-module, i2c_bus_cond_det.

Verification
REQ-036 Write to 0x69 with bytes 0x00..0x1F, then STOP -> 32 wr_valid_o pulses with data 0x00..0x1F, 33 ACKs, one stop_o.
REQ-037 Read from 0x69 with rd_data_i=0xA5 for 4 bytes, master NACK on the last -> SDA carries 0xA5 four times, 4 rd_req_o pulses, block in WAIT_STOP.
REQ-038 Address 0x42 -> no ACK (SDA high on the 9th clock), no wr_valid_o, busy_o=0.
REQ-039 Write 0x12 then a repeated START with a read of 0x69 -> start_o pulses twice, the R/W=1 path runs, no stop_o in between.
REQ-040 rst_n_i=0 during bit 4 of a read byte -> sda_o=1 within the same cycle; the next full transfer completes correctly.
